div_seq: RTL and testbench

Multi-cycle radix-2 integer divider with sequencing FSM, serving the execute stage's divide/remainder ops (div, rem, divw, remw and unsigned forms). EX raises `div_valid` and stalls while `div_valid & ~div_ready`. This block captures operands, iterates a restoring shift-subtract datapath and returns `{remainder, quotient}` on `div_result`. It also resolves divide-by-zero and signed overflow, and aborts on pipeline flush.

---
 rtl/div_seq_pkg.sv | 14 +
 rtl/div_step.sv | 27 ++
 rtl/div_seq.sv | 154 +++++++++++++++
 tb/tb_div_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
package div_seq_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } div_state_e;

  // Word width of the divw/remw forms.
  localparam int unsigned DivHalfW = 32;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on a {rem, quo} pair.
module div_step #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] quo_i,
  input  logic [Width-1:0] dsr_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] quo_o
);

  // One extra bit: the shifted partial remainder can reach 2*divisor-1.
  logic [Width:0] shifted;

  assign shifted = {rem_i, quo_i[Width-1]};

  always_comb begin
    if (shifted >= {1'b0, dsr_i}) begin
      rem_o = shifted[Width-1:0] - dsr_i;
      quo_o = {quo_i[Width-2:0], 1'b1};
    end else begin
      rem_o = shifted[Width-1:0];
      quo_o = {quo_i[Width-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider returning {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to finish at once when |dividend| < |divisor|.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DIV_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_valid,
  input  logic               div_32,
  input  logic               div_signed,
  input  logic [DIV_W-1:0]   dividend,
  input  logic [DIV_W-1:0]   divisor,
  input  logic               flush,
  output logic               div_ready,
  output logic [2*DIV_W-1:0] div_result,
  output logic               div_busy
);

  localparam int unsigned CntW = $clog2(DIV_W + 1);

  div_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]     rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d, w32_q, w32_d;
  logic [2*DIV_W-1:0]   res_q, res_d;

  logic [DIV_W-1:0]     a_ext, b_ext, a_mag, b_mag, min_neg;
  logic [DIV_W-1:0]     step_rem, step_quo;
  logic                 a_neg, b_neg, div_zero, ovf, early, accept;

  // Narrow results are always sign-extended from bit 31.
  function automatic logic [DIV_W-1:0] fit(input logic w32, input logic [DIV_W-1:0] v);
    return w32 ? {{(DIV_W-DivHalfW){v[DivHalfW-1]}}, v[DivHalfW-1:0]} : v;
  endfunction

  always_comb begin
    a_ext   = dividend;
    b_ext   = divisor;
    min_neg = {1'b1, {(DIV_W-1){1'b0}}};
    if (div_32) begin
      a_ext   = {{(DIV_W-DivHalfW){div_signed & dividend[DivHalfW-1]}},
                 dividend[DivHalfW-1:0]};
      b_ext   = {{(DIV_W-DivHalfW){div_signed & divisor[DivHalfW-1]}},
                 divisor[DivHalfW-1:0]};
      min_neg = {{(DIV_W-DivHalfW+1){1'b1}}, {(DivHalfW-1){1'b0}}};
    end
    a_neg    = div_signed & a_ext[DIV_W-1];
    b_neg    = div_signed & b_ext[DIV_W-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = div_signed & (a_ext == min_neg) & (b_ext == '1);
`ifdef DIV_EARLY_OUT_EN
    early    = ~div_zero & (a_mag < b_mag);
`else
    early    = 1'b0;
`endif
    accept   = div_valid & ~flush;
  end

  div_step #(
    .Width (DIV_W)
  ) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      w32_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      w32_q   <= w32_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (accept) state_d = (div_zero | ovf | early) ? StDone : StCalc;
      StCalc: if (cnt_q == CntW'(1)) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    w32_d  = w32_q;
    res_d  = res_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          // Narrow dividends sit in the top half so N shifts drain them fully.
          rem_d  = '0;
          quo_d  = div_32 ? (a_mag << DivHalfW) : a_mag;
          dsr_d  = b_mag;
          cnt_d  = div_32 ? CntW'(DivHalfW) : CntW'(DIV_W);
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          w32_d  = div_32;
          if (div_zero)   res_d = {fit(div_32, a_ext), {DIV_W{1'b1}}};
          else if (ovf)   res_d = {{DIV_W{1'b0}}, a_ext};
          else if (early) res_d = {fit(div_32, a_ext), {DIV_W{1'b0}}};
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CntW'(1);
      end
      StFix: begin
        if (!flush) begin
          res_d = {fit(w32_q, rneg_q ? -rem_q : rem_q), fit(w32_q, qneg_q ? -quo_q : quo_q)};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    div_ready  = (state_q == StDone);
    div_busy   = (state_q != StIdle);
    div_result = res_q;
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: arithmetic reference model plus per-cycle handshake checks.
module tb_div_seq;

  localparam time Period = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         div_valid = 1'b0;
  logic         div_32 = 1'b0;
  logic         div_signed = 1'b0;
  logic         flush = 1'b0;
  logic [63:0]  dividend = '0;
  logic [63:0]  divisor = '0;
  logic         div_ready, div_busy;
  logic [127:0] div_result;

  int           n_tests = 0;
  int           n_fail = 0;
  logic         chk_en = 1'b0;
  logic         zero_chk = 1'b0;
  logic         lit_en = 1'b0;
  logic [127:0] exp_res = '0;
  logic [127:0] lit_exp = '0;
  logic [127:0] last_res = '0;
  int           exp_lat = 0;
  int           kill_cyc = 0;
  time          t0 = 0;
  string        lit_name = "";

  always #(Period/2) clk = ~clk;

  div_seq #(
    .DIV_W (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .div_valid  (div_valid),
    .div_32     (div_32),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .flush      (flush),
    .div_ready  (div_ready),
    .div_result (div_result),
    .div_busy   (div_busy)
  );

  // Reference results from native arithmetic (truncating division, RISC-V corner rules).
  function automatic logic [127:0] model(input logic w32, input logic sg,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32;
    logic [63:0] q, r;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w32) begin
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (sg && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (sg) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      return {{32{r32[31]}}, r32, {32{q32[31]}}, q32};
    end
    if (b == 64'd0) begin
      q = '1; r = a;
    end else if (sg && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q = a; r = 64'd0;
    end else if (sg) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  function automatic longint unsigned mag(input logic w32, input logic sg, input logic [63:0] v);
    longint signed s;
    if (w32) s = sg ? longint'($signed(v[31:0])) : longint'({32'd0, v[31:0]});
    else     s = longint'(v);
    return (sg && s < 0) ? longint'(-s) : longint'(v & (w32 ? 64'hFFFF_FFFF : '1));
  endfunction

  function automatic int latency(input logic w32, input logic sg,
                                 input logic [63:0] a, input logic [63:0] b);
    if (mag(w32, sg, b) == 0) return 1;
    if (w32 && sg && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
    if (!w32 && sg && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (mag(w32, sg, a) < mag(w32, sg, b)) return 1;
`endif
    return w32 ? 34 : 66;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Single compare process: all checks are made here, on the falling edge.
  always @(negedge clk) begin
    int   cyc;
    logic ready_e, busy_e;
    cyc = int'(($time - t0) / Period);
    if (zero_chk) begin
      check("rst_ready", {127'd0, div_ready}, 128'd0);
      check("rst_busy", {127'd0, div_busy}, 128'd0);
      check("rst_result", div_result, 128'd0);
    end else if (chk_en) begin
      ready_e = (cyc == exp_lat) && (exp_lat <= kill_cyc);
      busy_e  = (cyc >= 1) && (cyc <= exp_lat) && (cyc <= kill_cyc);
      check($sformatf("ready c%0d", cyc), {127'd0, div_ready}, {127'd0, ready_e});
      check($sformatf("busy c%0d", cyc), {127'd0, div_busy}, {127'd0, busy_e});
      if (ready_e) check($sformatf("result c%0d", cyc), div_result, exp_res);
    end
    if (lit_en) check(lit_name, div_result, lit_exp);
  end

  // Called at posedge+1; that cycle is cycle 0.
  task automatic start_op(input logic w32, input logic sg, input logic [63:0] a,
                          input logic [63:0] b, input int kill);
    div_32     = w32;
    div_signed = sg;
    dividend   = a;
    divisor    = b;
    div_valid  = 1'b1;
    exp_res    = model(w32, sg, a, b);
    exp_lat    = latency(w32, sg, a, b);
    kill_cyc   = kill;
    t0         = $time;
    chk_en     = 1'b1;
  endtask

  task automatic run_op(input logic w32, input logic sg, input logic [63:0] a,
                        input logic [63:0] b, input logic [127:0] lit, input string name);
    start_op(w32, sg, a, b, 1000);
    repeat (exp_lat + 1) @(posedge clk);
    #1 div_valid = 1'b0;
    last_res = exp_res;
    lit_exp  = lit;
    lit_name = name;
    lit_en   = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b0;
    lit_en = 1'b0;
  endtask

  // Flush in cycle k (k == 0: flush together with the request in IDLE).
  task automatic run_kill(input logic [63:0] a, input logic [63:0] b, input int k,
                          input string name);
    start_op(1'b0, 1'b0, a, b, k);
    if (k == 0) begin
      flush = 1'b1;
    end else begin
      repeat (k) @(posedge clk);
      #1 flush = 1'b1;
      div_valid = 1'b0;
    end
    @(posedge clk);
    #1 flush = 1'b0;
    div_valid = 1'b0;
    lit_exp  = last_res;
    lit_name = name;
    lit_en   = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b0;
    lit_en = 1'b0;
  endtask

  initial begin
    zero_chk = 1'b1;
    repeat (2) @(posedge clk);
    #1 zero_chk = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    run_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD}, "lit_neg7_div2");
    run_op(1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h10,
           {64'h0000_0000_0000_000F, 64'h0000_0000_0FFF_FFFF}, "lit_u32_ffffffff_div16");
    run_op(1'b0, 1'b1, 64'd42, 64'd0,
           {64'd42, 64'hFFFF_FFFF_FFFF_FFFF}, "lit_42_div0");
    run_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
           {64'd0, 64'hFFFF_FFFF_8000_0000}, "lit_s32_overflow");
    run_kill(64'd1000, 64'd3, 10, "lit_hold_after_flush");
    run_op(1'b0, 1'b0, 64'd100, 64'd7, {64'd2, 64'd14}, "lit_100_div7");
    run_kill(64'd55, 64'd5, 0, "lit_hold_flush_wins");

    // Reset in cycle 20 of a long op.
    start_op(1'b0, 1'b0, 64'd123456, 64'd7, 1000);
    repeat (20) @(posedge clk);
    #1 chk_en = 1'b0;
    zero_chk  = 1'b1;
    div_valid = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 zero_chk = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(1'b0, 1'b0, 64'd9, 64'd3, {64'd0, 64'd3}, "lit_9_div3");

    run_op(1'b0, 1'b0, 64'd3, 64'd5, {64'd3, 64'd0}, "lit_3_div5");
    run_op(1'b1, 1'b1, 64'h1234_5678_FFFF_FF9C, 64'd7,
           {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2}, "lit_s32_m100_div7");
    run_op(1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
           {64'd1, 64'hFFFF_FFFF_FFFF_FFFD}, "lit_7_divm2");
    run_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
           {64'd0, 64'h5555_5555_5555_5555}, "lit_umax_div3");
    run_op(1'b1, 1'b0, 64'h0000_0000_8000_0001, 64'hABCD_0000_0000_0000,
           {64'hFFFF_FFFF_8000_0001, 64'hFFFF_FFFF_FFFF_FFFF}, "lit_u32_div0");
    run_op(1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           {64'd0, 64'h8000_0000_0000_0000}, "lit_s64_overflow");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
